// File: rtl/matrix_mem_pkg.sv
// Shared types and sizing helpers for the matrix operand store.
// Used by matrix_mem_bank, matrix_store and matrix_mem_bank_if.
// Optional build macro used elsewhere: MATRIX_MEM_OVF_FLAG_EN (sticky ovf_err port).
package matrix_mem_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Elements per matrix.
  function automatic int depth(input int n);
    return n * n;
  endfunction

  // Write pointer must be able to hold DEPTH itself (the saturated value).
  function automatic int ptr_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  // Step index width; N >= 2 keeps this at least 1 bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mem_bank_if.sv
// Operand stream bus from the operand store to the MAC array.
//   master (store) : out_valid, step_idx, data_outw, data_outx, done
//   slave  (MAC)   : out_ready
// data_outw slice i = W[i*N+k], data_outx slice j = X[k*N+j], slice 0 in LSBs.
interface matrix_mem_bank_if
  import matrix_mem_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 4
);
  logic                   out_valid;
  logic                   out_ready;
  logic [idx_w(N)-1:0]    step_idx;
  logic [N*DATA_W-1:0]    data_outw;
  logic [N*DATA_W-1:0]    data_outx;
  logic                   done;

  modport master (
    output out_valid, step_idx, data_outw, data_outx, done,
    input  out_ready
  );

  modport slave (
    input  out_valid, step_idx, data_outw, data_outx, done,
    output out_ready
  );
endinterface

// File: rtl/matrix_mem_bank_store.sv
// matrix_store: storage and write pointer for one N x N matrix, row-major.
// Ports:
//   clk, clear (sync, active high)  -- clear zeroes pointer and storage
//   wr_en, wr_data                  -- append one element at the pointer
//   full                            -- registered, high once N*N elements written
//   rd_bus                          -- all N*N elements, element 0 in the LSBs
// Writes while full are ignored; the pointer saturates at N*N.
module matrix_store
  import matrix_mem_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    full,
  output logic [N*N*DATA_W-1:0]   rd_bus
);
  localparam int DEPTH = depth(N);
  localparam int PTR_W = ptr_w(N);

  logic [PTR_W-1:0]                ptr_q;
  logic [DEPTH-1:0][DATA_W-1:0]    mem_q;
  logic                            full_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      ptr_q  <= '0;
      mem_q  <= '0;
      full_q <= 1'b0;
    end else if (wr_en && !full_q) begin
      mem_q[ptr_q] <= wr_data;
      ptr_q        <= ptr_q + 1'b1;
      // Flag rises together with the pointer reaching DEPTH.
      full_q       <= (ptr_q == PTR_W'(DEPTH - 1));
    end
  end

  assign full   = full_q;
  assign rd_bus = mem_q;
endmodule

// File: rtl/matrix_mem_bank.sv
// matrix_mem_bank: operand store for the N x N matrix multiplier.
// Serially loads W then/or X (row-major), then streams N operand vectors:
// step k carries column k of W and row k of X over a valid/ready bus.
// Ports:
//   clk, clear            -- clock, sync active-high reset
//   data_in, load_w/x     -- element write; load_w wins over load_x
//   w_full, x_full        -- matrix completely written
//   start                 -- both full, no stream running (state FULL)
//   unload_req            -- begin a stream, honoured only in FULL
//   strm (master)         -- out_valid/out_ready/step_idx/data_outw/data_outx/done
//   ovf_err               -- only with MATRIX_MEM_OVF_FLAG_EN: sticky dropped-write flag
// All outputs are registered; data buses read 0 while out_valid is low.
module matrix_mem_bank
  import matrix_mem_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int N      = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_w,
  input  logic              load_x,
  output logic              w_full,
  output logic              x_full,
  output logic              start,
  input  logic              unload_req,
`ifdef MATRIX_MEM_OVF_FLAG_EN
  output logic              ovf_err,
`endif
  matrix_mem_bank_if.master strm
);
  localparam int DEPTH = depth(N);
  localparam int PTR_W = ptr_w(N);
  localparam int IDX_W = idx_w(N);

  state_e                        state_q;
  logic [IDX_W-1:0]              step_q;
  logic                          valid_q, done_q, start_q;
  logic [N-1:0][DATA_W-1:0]      wv_q, xv_q, wv_d, xv_d;

  logic [DEPTH-1:0][DATA_W-1:0]  w_mem, x_mem;
  logic                          w_full_s, x_full_s;
  logic                          streaming, w_we, x_we;

  assign streaming = (state_q == STREAM);
  // Storage is frozen during a stream so the vectors stay consistent.
  assign w_we = load_w && !w_full_s && !streaming;
  assign x_we = load_x && !load_w && !x_full_s && !streaming;

  matrix_store #(.N(N), .DATA_W(DATA_W)) u_w (
    .clk(clk), .clear(clear), .wr_en(w_we), .wr_data(data_in),
    .full(w_full_s), .rd_bus(w_mem)
  );

  matrix_store #(.N(N), .DATA_W(DATA_W)) u_x (
    .clk(clk), .clear(clear), .wr_en(x_we), .wr_data(data_in),
    .full(x_full_s), .rd_bus(x_mem)
  );

  // Vector for the step that will be presented after the next edge:
  // step 0 when launching from FULL, step_q+1 while streaming.
  always_comb begin
    int               k;
    logic [PTR_W-1:0] wi, xi;
    wv_d = '0;
    xv_d = '0;
    k    = streaming ? int'(step_q) + 1 : 0;
    if (k >= N) k = 0;
    for (int i = 0; i < N; i++) begin
      wi      = PTR_W'(i * N + k);
      xi      = PTR_W'(k * N + i);
      wv_d[i] = w_mem[wi];
      xv_d[i] = x_mem[xi];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= LOAD;
      step_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      wv_q    <= '0;
      xv_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (w_full_s && x_full_s) begin
            state_q <= FULL;
            start_q <= 1'b1;
          end
        end
        FULL: begin
          if (unload_req) begin
            state_q <= STREAM;
            start_q <= 1'b0;
            valid_q <= 1'b1;
            step_q  <= '0;
            wv_q    <= wv_d;
            xv_q    <= xv_d;
          end
        end
        STREAM: begin
          if (valid_q && strm.out_ready) begin
            if (step_q == IDX_W'(N - 1)) begin
              state_q <= FULL;
              start_q <= 1'b1;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              step_q  <= '0;
              wv_q    <= '0;
              xv_q    <= '0;
            end else begin
              step_q <= step_q + 1'b1;
              wv_q   <= wv_d;
              xv_q   <= xv_d;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

`ifdef MATRIX_MEM_OVF_FLAG_EN
  logic ovf_q, drop;
  // X half of a simultaneous load counts as dropped.
  assign drop = (load_w && (w_full_s || streaming)) ||
                (load_x && (load_w || x_full_s || streaming));

  always_ff @(posedge clk) begin
    if (clear)     ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign ovf_err = ovf_q;
`endif

  assign w_full         = w_full_s;
  assign x_full         = x_full_s;
  assign start          = start_q;
  assign strm.out_valid = valid_q;
  assign strm.step_idx  = step_q;
  assign strm.data_outw = wv_q;
  assign strm.data_outx = xv_q;
  assign strm.done      = done_q;
endmodule

// File: tb/tb_matrix_mem_bank.sv
module tb_matrix_mem_bank;
  localparam int N      = 3;
  localparam int DATA_W = 4;
  localparam int DEPTH  = N * N;
  localparam int MASK   = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              clear = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              load_w = 1'b0, load_x = 1'b0, unload_req = 1'b0;
  logic              w_full, x_full, start;
`ifdef MATRIX_MEM_OVF_FLAG_EN
  logic              ovf_err;
`endif

  matrix_mem_bank_if #(.N(N), .DATA_W(DATA_W)) strm ();

  matrix_mem_bank #(.DATA_W(DATA_W), .N(N)) dut (
    .clk(clk), .clear(clear), .data_in(data_in),
    .load_w(load_w), .load_x(load_x),
    .w_full(w_full), .x_full(x_full), .start(start),
    .unload_req(unload_req),
`ifdef MATRIX_MEM_OVF_FLAG_EN
    .ovf_err(ovf_err),
`endif
    .strm(strm)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // Reference model: matrices as plain arrays plus fill counts.
  int mw[DEPTH], mx[DEPTH];
  int wp, xp;
  bit ovf_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wvec(input int k);
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v |= 64'(mw[i*N+k] & MASK) << (i * DATA_W);
    return v;
  endfunction

  function automatic logic [63:0] xvec(input int k);
    logic [63:0] v = '0;
    for (int j = 0; j < N; j++) v |= 64'(mx[k*N+j] & MASK) << (j * DATA_W);
    return v;
  endfunction

  task automatic model_reset();
    wp = 0; xp = 0; ovf_m = 0;
    for (int i = 0; i < DEPTH; i++) begin mw[i] = 0; mx[i] = 0; end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    model_reset();
  endtask

  task automatic chk_ovf();
`ifdef MATRIX_MEM_OVF_FLAG_EN
    chk("ovf_err", ovf_err, ovf_m);
`endif
  endtask

  // One load cycle outside a stream; model applies W priority and saturation.
  task automatic drive_load(input bit lw, input bit lx, input int d);
    load_w = lw; load_x = lx; data_in = DATA_W'(d);
    tick();
    load_w = 1'b0; load_x = 1'b0;
    if (lw) begin
      if (wp < DEPTH) begin mw[wp] = d & MASK; wp++; end else ovf_m = 1;
    end
    if (lx) begin
      if (!lw && xp < DEPTH) begin mx[xp] = d & MASK; xp++; end else ovf_m = 1;
    end
    chk("w_full", w_full, wp == DEPTH);
    chk("x_full", x_full, xp == DEPTH);
    chk_ovf();
  endtask

  task automatic fill_random();
    for (int c = 0; c < 300 && (wp < DEPTH || xp < DEPTH); c++)
      drive_load($urandom % 2, $urandom % 2, $urandom & MASK);
    chk("fill_done", (wp == DEPTH) && (xp == DEPTH), 1);
  endtask

  task automatic wait_start();
    for (int c = 0; c < 4 && !start; c++) tick();
    chk("start_wait", start, 1);
  endtask

  // mode 0: always ready; 1: random ready plus ignored loads/unload_req;
  // 2: stall 3 cycles at step 1. stop_at >= 0 returns while that step is shown.
  task automatic stream(input int mode, input int stop_at,
                        input bit use0, input logic [63:0] w0, input logic [63:0] x0);
    int  k = 0, stall = 0;
    bit  rdy, hs, fin = 0;
    unload_req = 1'b1; tick(); unload_req = 1'b0;
    chk("first_valid", strm.out_valid, 1);
    chk("start_low", start, 0);
    if (use0) begin
      chk("step0_w_const", strm.data_outw, w0);
      chk("step0_x_const", strm.data_outx, x0);
    end
    for (int c = 0; c < 200 && !fin; c++) begin
      if (k == stop_at) begin fin = 1; break; end
      case (mode)
        0: rdy = 1;
        2: rdy = !(k == 1 && stall < 3);
        default: rdy = $urandom % 2;
      endcase
      if (mode == 1) begin
        load_w = $urandom % 2; load_x = $urandom % 2;
        data_in = DATA_W'($urandom); unload_req = $urandom % 2;
        if (load_w || load_x) ovf_m = 1;
      end
      strm.out_ready = rdy;
      chk("valid", strm.out_valid, 1);
      chk("step_idx", strm.step_idx, k);
      chk("data_w", strm.data_outw, wvec(k));
      chk("data_x", strm.data_outx, xvec(k));
      hs = rdy;
      if (!hs && k == 1) stall++;
      tick();
      load_w = 0; load_x = 0; unload_req = 0;
      if (hs && k == N - 1) begin
        chk("done", strm.done, 1);
        chk("valid_end", strm.out_valid, 0);
        chk("data_w_idle", strm.data_outw, 0);
        chk("start_again", start, 1);
        fin = 1;
      end else begin
        chk("done_low", strm.done, 0);
        if (hs) k++;
      end
    end
    strm.out_ready = 1'b0;
    chk("stream_finished", fin, 1);
    if (mode == 2) chk("stall_cycles", stall, 3);
    chk_ovf();
  endtask

  initial begin
    strm.out_ready = 1'b0;
    model_reset();
    // Reset state
    tick(); clear = 1'b0;
    chk("rst_w_full", w_full, 0);
    chk("rst_x_full", x_full, 0);
    chk("rst_start", start, 0);
    chk("rst_valid", strm.out_valid, 0);
    chk("rst_step", strm.step_idx, 0);
    chk("rst_dw", strm.data_outw, 0);
    chk("rst_dx", strm.data_outx, 0);
    chk("rst_done", strm.done, 0);
    chk_ovf();

    // Directed: W=1..9, X=9..1, always ready, then re-stream
    for (int i = 0; i < DEPTH; i++) drive_load(1, 0, i + 1);
    for (int i = 0; i < DEPTH; i++) drive_load(0, 1, DEPTH - i);
    wait_start();
    stream(0, -1, 1, 64'h741, 64'h789);
    tick();
    chk("idle_after_done", strm.out_valid, 0);
    chk("done_one_cycle", strm.done, 0);
    stream(2, -1, 1, 64'h741, 64'h789);
    stream(1, -1, 0, 0, 0);

    // Overload W with 11 writes
    do_clear();
    for (int v = 1; v <= 11; v++) drive_load(1, 0, v);
    for (int i = 0; i < DEPTH; i++) drive_load(0, 1, $urandom & MASK);
    wait_start();
    stream(0, -1, 0, 0, 0);

    // Simultaneous load at empty: W gets 5, X stays empty
    do_clear();
    drive_load(1, 1, 5);
    chk("simul_xfull", x_full, 0);
    fill_random();
    wait_start();
    stream(1, -1, 0, 0, 0);

    // Clear mid-stream at step 1
    stream(0, 1, 0, 0, 0);
    chk("mid_step1", strm.step_idx, 1);
    clear = 1'b1; strm.out_ready = 1'b1; tick(); clear = 1'b0; strm.out_ready = 1'b0;
    model_reset();
    chk("clr_valid", strm.out_valid, 0);
    chk("clr_start", start, 0);
    chk("clr_w_full", w_full, 0);
    chk("clr_x_full", x_full, 0);
    chk("clr_step", strm.step_idx, 0);
    chk("clr_dw", strm.data_outw, 0);
    chk("clr_dx", strm.data_outx, 0);
    chk("clr_done", strm.done, 0);
    chk_ovf();
    // unload_req in LOAD is ignored
    unload_req = 1'b1; tick(); unload_req = 1'b0;
    chk("load_unload_ign", strm.out_valid, 0);
    fill_random();
    wait_start();
    stream(2, -1, 0, 0, 0);
    stream(1, -1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/matrix_mem_bank.md
Name: matrix_mem_bank

Overview:
- Parametrised operand store for the N x N matrix multiplier.
- Serially loads two N x N matrices, W and X, row-major, DATA_W bits per element.
- After both are full, streams N operand vectors to the multiply-accumulate array under a valid/ready handshake.
  - Step k carries column k of W and row k of X.
- Replaces the fixed 3x3, 4-bit, three-strobe unload scheme with a sequenced, back-pressured stream.

Parameters:
- DATA_W, 4, element width in bits.
- N, 3, matrix dimension (N >= 2); each matrix holds N*N elements.

Ports:
- clk  in  1  clock, all logic on rising edge.
- clear  in  1  synchronous active-high reset.
- data_in  in  DATA_W  element to be written.
- load_w  in  1  write data_in into the next W slot this cycle.
- load_x  in  1  write data_in into the next X slot this cycle.
- w_full  out  1  all N*N W slots written.
- x_full  out  1  all N*N X slots written.
- start  out  1  high while both matrices are full and no stream is in progress.
- unload_req  in  1  pulse to begin streaming; honoured only while start=1.
- out_valid  out  1  operand vector on outputs is valid.
- out_ready  in  1  consumer accepts the vector when out_valid and out_ready are both high.
- step_idx  out  clog2(N)  index k of the current vector.
- data_outw  out  N*DATA_W  slice i is W[i*N+k], slice 0 in the LSBs.
- data_outx  out  N*DATA_W  slice j is X[k*N+j], slice 0 in the LSBs.
- done  out  1  one-cycle pulse when the final vector is accepted.

Behaviour:
- Reset: clear=1 at a clock edge has the following effect, regardless of state or stream progress:
  - Both write pointers go to 0 and all storage is zeroed.
  - State goes to LOAD.
  - All outputs go to 0: w_full, x_full, start, out_valid, step_idx, data_outw, data_outx, done.
- Writes:
  - A W write stores at w_ptr and increments it. When w_ptr reaches N*N, w_full=1 from the next cycle.
  - X writes behave the same way with x_ptr and x_full.
- Simultaneous load_w and load_x: W takes priority and the X element is dropped.
- Writes to a full matrix, and any writes in state STREAM, are ignored; pointers saturate at N*N, with no wrap.
- FSM states: LOAD, FULL, STREAM.
  - LOAD -> FULL when w_full and x_full are both 1. start=1 in FULL only.
  - FULL -> STREAM on unload_req=1. Next cycle: out_valid=1, step_idx=0, outputs carry step 0. unload_req in LOAD or STREAM is ignored.
  - In STREAM, the outputs hold stable while out_valid=1 and out_ready=0.
  - On a handshake with step_idx<N-1: step_idx increments and the next vector appears on the following cycle, so back-to-back transfers run at one vector per cycle.
  - On a handshake with step_idx=N-1: done=1 for one cycle, out_valid=0, and state -> FULL.
  - Storage is retained, so the same operands can be re-streamed with another unload_req.
- A new matrix pair requires clear; partial reload is not supported.
- When out_valid=0, data_outw and data_outx drive 0.
- All outputs are registered; unload_req-to-first-valid latency is 1 cycle.

Optional Feature:
- Macro: MATRIX_MEM_OVF_FLAG_EN.
- With the macro defined:
  - Extra output port ovf_err (1 bit), sticky.
  - ovf_err is set the cycle after any dropped write: load_w while W full, load_x while X full, any load in STREAM, or the X half of a simultaneous load.
  - Cleared only by clear.
- Without the macro: the port is absent, and dropped writes are silently ignored as described above.

Decomposition:
- Package matrix_mem_pkg holds:
  - the state enum (LOAD, FULL, STREAM);
  - localparam helpers DEPTH=N*N, PTR_W=clog2(DEPTH+1), IDX_W=clog2(N), as functions of N.
- Sub-module matrix_store holds the storage and pointer logic for one matrix.
  - Instantiated twice, for W and X.
  - Ports: clk, clear, wr_en, wr_data, full, plus a flat read bus of all N*N elements.
  - The top level performs column/row selection by step_idx.

Test Plan:
- N=3, DATA_W=4: load W=1..9 and X=9..1, then unload_req with out_ready held 1.
  - Expect step0 W slices {1,4,7}, X slices {9,8,7}; step1 {2,5,8},{6,5,4}; step2 {3,6,9},{3,2,1}.
  - Expect done on the cycle step 2 is accepted, then start=1 again.
- Back-pressure: out_ready=0 for 3 cycles at step 1.
  - Expect step_idx=1 and data held stable, with no done.
  - After out_ready rises, step 2 follows on the next cycle.
- Overload: write 11 W elements (values 1..11).
  - Expect w_full=1 after the 9th write, and W[8]=9 unchanged.
  - With MATRIX_MEM_OVF_FLAG_EN, expect ovf_err=1.
- Simultaneous load_w=load_x=1 with data_in=5 at empty.
  - Expect W[0]=5, x_ptr=0.
  - With the macro, expect ovf_err=1.
- clear asserted mid-stream at step 1.
  - Next cycle: out_valid=0, start=0, w_full=x_full=0, and all outputs 0.
  - After a fresh load and stream, step 0 carries only the new data.
- Re-stream: after done, issue unload_req again; the identical 3-vector sequence repeats.
  - unload_req during LOAD or STREAM has no effect.
